// File: rtl/cf_input_deser.sv
// Serial-to-parallel feeder for the cf stage: collects a framed bit stream into a
// registered NBITS-wide vector and holds it under valid/ready. Optional parity: CF_DESER_PARITY_EN.
module cf_input_deser #(
    parameter int NBITS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_start,
    output logic             sin_ready,
    output logic [NBITS-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             frame_err,
    output logic [4:0]       bit_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data and valid until that edge, ready never waits on valid.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_bit_cnt;
    logic [4:0]       w_cnt_nxt;
    logic [4:0]       w_wr_idx;
    logic [NBITS-1:0] r_vec;
    logic             r_frame_err;
    logic             w_err;
    logic             w_wr;
    logic             w_accept;
    logic             w_sin_ready;
    logic             w_vec_valid;
`ifdef CF_DESER_PARITY_EN
    logic             w_par_ok;
`endif

    assign w_accept = sin_valid & w_sin_ready;
`ifdef CF_DESER_PARITY_EN
    // Even parity: the trailing bit makes the total count of ones even.
    assign w_par_ok = ~((^r_vec) ^ sin_data);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_err       = 1'b0;
        w_wr        = 1'b0;
        w_wr_idx    = r_bit_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (sin_start) begin
                        w_wr        = 1'b1;
                        w_wr_idx    = 5'd0;
                        w_cnt_nxt   = 5'd1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    if (sin_start) begin
                        // Restart mid-frame: the new start bit begins a fresh frame.
                        w_err     = 1'b1;
                        w_wr      = 1'b1;
                        w_wr_idx  = 5'd0;
                        w_cnt_nxt = 5'd1;
`ifdef CF_DESER_PARITY_EN
                    end else if (r_bit_cnt == 5'(NBITS)) begin
                        if (w_par_ok) begin
                            w_cnt_nxt   = r_bit_cnt + 5'd1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_err       = 1'b1;
                            w_cnt_nxt   = 5'd0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_wr      = 1'b1;
                        w_cnt_nxt = r_bit_cnt + 5'd1;
                    end
`else
                    end else begin
                        w_wr      = 1'b1;
                        w_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'(NBITS - 1)) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
`endif
                end
            end
            S_HOLD: begin
                if (vec_ready) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = 5'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sin_ready = 1'b1;
        w_vec_valid = 1'b0;
        if (r_state == S_HOLD) begin
            w_sin_ready = 1'b0;
            w_vec_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec       <= '0;
            r_bit_cnt   <= 5'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_bit_cnt   <= w_cnt_nxt;
            r_frame_err <= w_err;
            for (int k = 0; k < NBITS; k++) begin
                if (w_wr && (w_wr_idx == 5'(k))) begin
                    r_vec[k] <= sin_data;
                end
            end
        end
    end

    assign sin_ready = w_sin_ready;
    assign vec_valid = w_vec_valid;
    assign vec_out   = r_vec;
    assign frame_err = r_frame_err;
    assign bit_cnt   = r_bit_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cf_input_deser.sv
// Directed bench for cf_input_deser; parity scenarios run when CF_DESER_PARITY_EN is defined.
module tb_cf_input_deser;

    localparam int NBITS = 9;
`ifdef CF_DESER_PARITY_EN
    localparam int FRAME_LEN = NBITS + 1;
`else
    localparam int FRAME_LEN = NBITS;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             sin_start = 1'b0;
    logic             sin_ready;
    logic [NBITS-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready = 1'b0;
    logic             frame_err;
    logic [4:0]       bit_cnt;
    logic [1:0]       dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    cf_input_deser #(.NBITS(NBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .sin_start (sin_start),
        .sin_ready (sin_ready),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic st, input logic d);
        int waited = 0;
        while (!sin_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("send_ready", 32'(sin_ready), 32'd1);
        sin_valid = 1'b1;
        sin_start = st;
        sin_data  = d;
        tick();
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin_data  = 1'b0;
    endtask

    task automatic send_tail(input logic [NBITS-1:0] v, input int from, input logic bad_par);
        for (int k = from; k < NBITS; k++) begin
            send_bit(1'b0, v[k]);
        end
`ifdef CF_DESER_PARITY_EN
        send_bit(1'b0, (^v) ^ bad_par);
`else
        if (bad_par) $display("note: parity disabled, bad_par ignored");
`endif
    endtask

    task automatic send_frame(input logic [NBITS-1:0] v);
        send_bit(1'b1, v[0]);
        send_tail(v, 1, 1'b0);
    endtask

    task automatic release_frame();
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vec"},   32'(vec_out),   32'd0);
        check({tag, "_valid"}, 32'(vec_valid), 32'd0);
        check({tag, "_err"},   32'(frame_err), 32'd0);
        check({tag, "_cnt"},   32'(bit_cnt),   32'd0);
        check({tag, "_ready"}, 32'(sin_ready), 32'd1);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int changes;
        tick();
        do_reset();
        check_reset_vals("rst0");

        // Frame 1: 0,1,0,1,0,1,0,1,1 -> 9'h1AA, held with vec_ready low.
        send_frame(9'h1AA);
        check("f1_valid", 32'(vec_valid), 32'd1);
        check("f1_vec",   32'(vec_out),   32'h1AA);
        check("f1_ready", 32'(sin_ready), 32'd0);
        check("f1_cnt",   32'(bit_cnt),   32'(FRAME_LEN));
        changes = 0;
        sin_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sin_start = 1'($urandom_range(0, 1));
            sin_data  = 1'($urandom_range(0, 1));
            tick();
            if (vec_out !== 9'h1AA || vec_valid !== 1'b1 || sin_ready !== 1'b0 ||
                bit_cnt !== 5'(FRAME_LEN) || frame_err !== 1'b0)
                changes++;
        end
        sin_valid = 1'b0;
        sin_start = 1'b0;
        check("hold_stable", 32'(changes), 32'd0);

        release_frame();
        check("rel_valid", 32'(vec_valid), 32'd0);
        check("rel_ready", 32'(sin_ready), 32'd1);
        check("rel_cnt",   32'(bit_cnt),   32'd0);
        check("rel_state", 32'(dbg_state), 32'd0);

        // Frame 2: 1,1,0,1,1,1,0,0,1 -> 9'h13B.
        send_frame(9'h13B);
        check("f2_valid", 32'(vec_valid), 32'd1);
        check("f2_vec",   32'(vec_out),   32'h13B);
        release_frame();

        // vec_ready with nothing valid does nothing.
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        check("idle_rdy_valid", 32'(vec_valid), 32'd0);
        check("idle_rdy_state", 32'(dbg_state), 32'd0);

        // Non-start bits in IDLE: back-to-back error pulses.
        send_bit(1'b0, 1'b1);
        check("idle_err1",   32'(frame_err), 32'd1);
        check("idle_err_cnt", 32'(bit_cnt),  32'd0);
        send_bit(1'b0, 1'b0);
        check("idle_err2",   32'(frame_err), 32'd1);
        check("idle_err_vv", 32'(vec_valid), 32'd0);
        tick();
        check("idle_err_end", 32'(frame_err), 32'd0);
        check("idle_err_st",  32'(dbg_state), 32'd0);

        // Mid-frame restart: 4 bits of ones, then new frame 9'h0C9.
        send_bit(1'b1, 1'b1);
        for (int k = 1; k < 4; k++) send_bit(1'b0, 1'b1);
        check("rs_cnt4", 32'(bit_cnt),   32'd4);
        check("rs_st",   32'(dbg_state), 32'd1);
        send_bit(1'b1, 1'b1);
        check("rs_err", 32'(frame_err), 32'd1);
        check("rs_cnt1", 32'(bit_cnt),  32'd1);
        send_bit(1'b0, 1'b0);
        check("rs_err_end", 32'(frame_err), 32'd0);
        send_tail(9'h0C9, 2, 1'b0);
        check("rs_valid", 32'(vec_valid), 32'd1);
        check("rs_vec",   32'(vec_out),   32'h0C9);
        check("rs_cnt9",  32'(bit_cnt),   32'(FRAME_LEN));
        release_frame();

        // Reset in SHIFT after 5 bits.
        send_bit(1'b1, 1'b1);
        for (int k = 1; k < 5; k++) send_bit(1'b0, 1'b1);
        check("pre_rst_cnt", 32'(bit_cnt), 32'd5);
        do_reset();
        check_reset_vals("rst_shift");

        // Reset during HOLD.
        send_frame(9'h155);
        check("pre_rst_vv", 32'(vec_valid), 32'd1);
        do_reset();
        check_reset_vals("rst_hold");

`ifdef CF_DESER_PARITY_EN
        // 9'h1AA has five ones, so the good parity bit is 1.
        send_bit(1'b1, 1'b0);
        send_tail(9'h1AA, 1, 1'b0);
        check("par_ok_valid", 32'(vec_valid), 32'd1);
        check("par_ok_vec",   32'(vec_out),   32'h1AA);
        release_frame();
        send_bit(1'b1, 1'b0);
        send_tail(9'h1AA, 1, 1'b1);
        check("par_bad_err",   32'(frame_err), 32'd1);
        check("par_bad_valid", 32'(vec_valid), 32'd0);
        check("par_bad_cnt",   32'(bit_cnt),   32'd0);
        check("par_bad_state", 32'(dbg_state), 32'd0);
        tick();
        check("par_bad_end", 32'(frame_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cf_input_deser.md
Name: cf_input_deser

Overview:
- Upstream feeder for the 9-input combinational cf stage.
- Collects a serial bit stream into one registered NBITS-wide frame (bit k drives cf input Ik) and presents it with a valid/ready handshake.
- Holds each frame stable until the consumer accepts it, so cf sees a clean, glitch-free input vector for the whole presentation window.

Parameters:
- NBITS, 9, frame width in bits; equals the cf input count. Legal range 2..16.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- sin_valid  input  1  serial bit present on sin_data
- sin_data  input  1  serial data bit; first bit of a frame is I0
- sin_start  input  1  qualifies the current bit as the first bit of a frame
- sin_ready  output  1  deserializer can accept a bit this cycle
- vec_out  output  NBITS  assembled frame; bit k maps to cf input Ik
- vec_valid  output  1  vec_out holds a complete frame
- vec_ready  input  1  downstream accepts vec_out this cycle
- frame_err  output  1  one-cycle pulse on a framing error
- bit_cnt  output  5  number of bits captured in the current frame

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, vec_out=0, vec_valid=0, frame_err=0, bit_cnt=0. sin_ready reads 1 in the first cycle after reset.
- Bit transfer: a bit is accepted on a rising edge where sin_valid and sin_ready are both 1.
- State IDLE:
  - sin_ready=1.
  - Accepted bit with sin_start=1: write vec_out[0]=sin_data, bit_cnt=1, go to SHIFT.
  - Accepted bit with sin_start=0: drop the bit, pulse frame_err, stay in IDLE.
- State SHIFT:
  - sin_ready=1.
  - Accepted bit with sin_start=0: write vec_out[bit_cnt]=sin_data, bit_cnt+1.
  - The acceptance that writes index NBITS-1 moves to HOLD. vec_valid=1 the next cycle, so latency is 1 clk from last-bit acceptance to vec_valid.
  - Accepted bit with sin_start=1 (mid-frame restart): pulse frame_err, discard the partial frame, write vec_out[0]=sin_data, bit_cnt=1, stay in SHIFT.
  - Bits of vec_out not yet written in the current frame keep their old values. They are don't-care while vec_valid=0.
- State HOLD:
  - sin_ready=0, vec_valid=1; vec_out and bit_cnt are frozen.
  - sin_valid is ignored; the upstream must hold its bit.
  - vec_valid & vec_ready: next cycle vec_valid=0, bit_cnt=0, state=IDLE, sin_ready=1.
  - There is no same-cycle bypass: at least 1 idle cycle between frames.
- vec_ready while vec_valid=0 has no effect.
- frame_err is exactly 1 cycle wide per error event. Back-to-back errors give consecutive pulses.
- rst while in SHIFT or HOLD: abort the frame, drop vec_valid on the next edge, apply all reset values.
- bit_cnt width is fixed at 5 and never exceeds NBITS (or NBITS+1 with the optional feature below).

Optional Feature:
- Macro: CF_DESER_PARITY_EN.
- Defined:
  - A frame is NBITS+1 bits; the extra final bit is even parity over the NBITS data bits and is not stored in vec_out.
  - bit_cnt counts to NBITS+1.
  - Parity match: go to HOLD as normal.
  - Parity mismatch: pulse frame_err, no vec_valid, return to IDLE with bit_cnt=0.
- Undefined: a frame is NBITS bits, with no parity check and no parity logic.

Test Plan:
- Reset, then serial 0,1,0,1,0,1,0,1,1 (start on first bit), vec_ready=0 -> vec_out=9'h1AA, vec_valid=1 one clk after the 9th bit, sin_ready=0, value held for 20 clks.
- From that held state, pulse vec_ready for 1 clk, then send 1,1,0,1,1,1,0,0,1 -> vec_valid drops next clk, sin_ready=1, second frame vec_out=9'h13B.
- Bit with sin_start=0 in IDLE -> frame_err pulse of 1 clk, bit_cnt stays 0, no vec_valid.
- 4 bits, then a new sin_start bit, then 8 more bits (9 in the new frame) -> frame_err pulse at the restart, final vec_out holds only the new frame's bits, bit_cnt reaches 9.
- rst asserted after 5 bits, and separately during HOLD -> next clk all outputs equal reset values, state IDLE.
- With CF_DESER_PARITY_EN: frame 9'h1AA plus parity 1 -> vec_valid=1. Same frame with parity 0 -> frame_err pulse, no vec_valid, bit_cnt=0.
